// File: rtl/card_deck.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : card_deck
// Purpose  : 52-card register deck, Fisher-Yates shuffled by a free-running
//            6-bit LFSR, served one card per draw with a single-cycle valid.
// Option   : CARD_DECK_AUTO_RESHUFFLE_EN - rebuild the deck after the last draw
// Revision : 1.0 - initial release
// ============================================================================
module card_deck #(
  parameter logic [5:0] SEED = 6'b011110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_req,
  input  logic       draw_req,
  output logic       ready,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  localparam int         C_DECK_SIZE = 52;
  localparam logic [5:0] C_LAST_IDX  = 6'd51;
  localparam logic [5:0] C_FULL      = 6'd52;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] ptr_q, ptr_d;
  logic [5:0] left_q, left_d;
  logic       valid_q, valid_d;
  logic [3:0] rank_q, rank_d;
  logic [1:0] suit_q, suit_d;
  logic [3:0] value_q, value_d;
  logic [5:0] deck_q [C_DECK_SIZE];
  logic [5:0] deck_d [C_DECK_SIZE];

  logic [5:0] cand_j;
  logic [5:0] rd_idx;
  logic [5:0] rd_entry;
  logic [3:0] dec_rem;
  logic [3:0] dec_rank;
  logic [1:0] dec_suit;
  logic [3:0] dec_value;

  assign lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  assign cand_j = lfsr_q - 6'd1;
  // ptr_q reaches 52 once the deck is exhausted; keep the read in range.
  assign rd_idx = (ptr_q > C_LAST_IDX) ? 6'd0 : ptr_q;

  always_comb begin
    rd_entry = deck_q[rd_idx];
    dec_suit = 2'd0;
    dec_rem  = rd_entry[3:0];
    if (rd_entry >= 6'd39) begin
      dec_suit = 2'd3;
      dec_rem  = 4'(rd_entry - 6'd39);
    end else if (rd_entry >= 6'd26) begin
      dec_suit = 2'd2;
      dec_rem  = 4'(rd_entry - 6'd26);
    end else if (rd_entry >= 6'd13) begin
      dec_suit = 2'd1;
      dec_rem  = 4'(rd_entry - 6'd13);
    end
    dec_rank  = dec_rem + 4'd1;
    dec_value = (dec_rank > 4'd10) ? 4'd10 : dec_rank;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    valid_d = 1'b0;
    rank_d  = rank_q;
    suit_d  = suit_q;
    value_d = value_q;
    deck_d  = deck_q;
    case (state_q)
      ST_INIT: begin
        deck_d[idx_q] = idx_q;
        if (idx_q == C_LAST_IDX) begin
          state_d = ST_SHUFFLE;
          ptr_d   = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_SHUFFLE: begin
        // Candidates above the current index are rejected to keep the
        // permutation uniform.
        if (cand_j <= idx_q) begin
          deck_d[idx_q]  = deck_q[cand_j];
          deck_d[cand_j] = deck_q[idx_q];
          if (idx_q == 6'd1) begin
            state_d = ST_READY;
            left_d  = C_FULL;
          end else begin
            idx_d = idx_q - 6'd1;
          end
        end
      end
      ST_READY: begin
        if (shuffle_req) begin
          state_d = ST_INIT;
          idx_d   = 6'd0;
          left_d  = 6'd0;
        end else if (draw_req && (left_q != 6'd0)) begin
          valid_d = 1'b1;
          rank_d  = dec_rank;
          suit_d  = dec_suit;
          value_d = dec_value;
          ptr_d   = ptr_q + 6'd1;
          left_d  = left_q - 6'd1;
`ifdef CARD_DECK_AUTO_RESHUFFLE_EN
          if (left_q == 6'd1) begin
            state_d = ST_INIT;
            idx_d   = 6'd0;
          end
`endif
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      lfsr_q  <= SEED;
      idx_q   <= 6'd0;
      ptr_q   <= 6'd0;
      left_q  <= 6'd0;
      valid_q <= 1'b0;
      rank_q  <= 4'd0;
      suit_q  <= 2'd0;
      value_q <= 4'd0;
      for (int k = 0; k < C_DECK_SIZE; k++) deck_q[k] <= 6'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
      value_q <= value_d;
      deck_q  <= deck_d;
    end
  end

  assign ready      = (state_q == ST_READY);
  assign card_valid = valid_q;
  assign card_rank  = rank_q;
  assign card_suit  = suit_q;
  assign card_value = value_q;
  assign cards_left = left_q;
  assign deck_empty = ready && (left_q == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_card_deck.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_card_deck
// Purpose  : Self-checking bench for card_deck against a Fisher-Yates model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_deck;

  localparam logic [5:0] C_SEED = 6'b011110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shuffle_req = 1'b0;
  logic       draw_req = 1'b0;
  logic       ready;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       deck_empty;

  card_deck #(.SEED(C_SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .shuffle_req(shuffle_req),
    .draw_req   (draw_req),
    .ready      (ready),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_suit  (card_suit),
    .card_value (card_value),
    .cards_left (cards_left),
    .deck_empty (deck_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int model_deck [52];
  int first_deck [52];

  // Rising edges since reset release; lfsr value seen at edge n is step^n(SEED).
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  function automatic logic [5:0] lfsr_at(input int n);
    logic [5:0] l = C_SEED;
    for (int k = 0; k < n; k++) l = lfsr_step(l);
    return l;
  endfunction

  // Fisher-Yates with rejection, one candidate per cycle from start_edge.
  // Returns the edge count at which ready is first visible.
  task automatic predict(input int start_edge, output int ready_cyc);
    int i = 51;
    int n = start_edge;
    int j, t;
    logic [5:0] l;
    for (int k = 0; k < 52; k++) model_deck[k] = k;
    l = lfsr_at(start_edge);
    while (n < start_edge + 10000) begin
      j = int'(l) - 1;
      if (j <= i) begin
        t = model_deck[i];
        model_deck[i] = model_deck[j];
        model_deck[j] = t;
        if (i == 1) break;
        i--;
      end
      l = lfsr_step(l);
      n++;
    end
    ready_cyc = n + 1;
  endtask

  task automatic wait_ready(input string tag, input int exp_cyc, input int inj_draw, input int inj_shuf);
    int stray = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (card_valid) stray++;
      draw_req = 1'b0;
      shuffle_req = 1'b0;
      if (ready) seen = 1'b1;
      else begin
        if (cyc == inj_draw) draw_req = 1'b1;
        if (cyc == inj_shuf) shuffle_req = 1'b1;
      end
    end
    check({tag, " ready"}, 32'(seen), 1);
    check({tag, " ready_cycle"}, cyc, exp_cyc);
    check({tag, " stray_valid"}, stray, 0);
    check({tag, " cards_left"}, 32'(cards_left), 52);
    check({tag, " deck_empty"}, 32'(deck_empty), 0);
  endtask

  task automatic check_card(input string tag, input int entry, input int exp_left);
    int r = entry % 13 + 1;
    check({tag, " valid"}, 32'(card_valid), 1);
    check({tag, " rank"}, 32'(card_rank), r);
    check({tag, " suit"}, 32'(card_suit), entry / 13);
    check({tag, " value"}, 32'(card_value), (r > 10) ? 10 : r);
    check({tag, " cards_left"}, 32'(cards_left), exp_left);
  endtask

  task automatic draw_one(input string tag, input int entry, input int exp_left);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check_card(tag, entry, exp_left);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 32'(ready), 0);
    check({tag, " valid"}, 32'(card_valid), 0);
    check({tag, " rank"}, 32'(card_rank), 0);
    check({tag, " suit"}, 32'(card_suit), 0);
    check({tag, " value"}, 32'(card_value), 0);
    check({tag, " cards_left"}, 32'(cards_left), 0);
    check({tag, " deck_empty"}, 32'(deck_empty), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, c0, ptr, n, sum, uniq, idx;
    bit seen [52];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Boot with requests injected during INIT (cyc 30) and SHUFFLE (cyc 60).
    rst = 1'b1;
    predict(52, rc);
    first_deck = model_deck;
    wait_ready("boot", rc, 60, 30);

    // 52 back-to-back draws.
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    sum = 0;
    draw_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      if (k == 51) draw_req = 1'b0;
      check_card("deal", model_deck[k], 51 - k);
      idx = int'(card_suit) * 13 + int'(card_rank) - 1;
      if (card_valid && idx >= 0 && idx < 52) seen[idx] = 1'b1;
      sum += int'(card_value);
    end
    uniq = 0;
    for (int k = 0; k < 52; k++) if (seen[k]) uniq++;
    check("deal unique_cards", uniq, 52);
    check("deal value_sum", sum, 340);

`ifdef CARD_DECK_AUTO_RESHUFFLE_EN
    c0 = cyc - 1;
    @(negedge clk);
    check("auto ready_low", 32'(ready), 0);
    check("auto deck_empty", 32'(deck_empty), 0);
    check("auto valid_drop", 32'(card_valid), 0);
    predict(c0 + 53, rc);
    wait_ready("auto", rc, -1, -1);
`else
    check("empty deck_empty", 32'(deck_empty), 1);
    check("empty ready", 32'(ready), 1);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check("draw53 valid", 32'(card_valid), 0);
    check("draw53 rank_hold", 32'(card_rank), model_deck[51] % 13 + 1);
    check("draw53 suit_hold", 32'(card_suit), model_deck[51] / 13);
    check("draw53 cards_left", 32'(cards_left), 0);
    check("draw53 deck_empty", 32'(deck_empty), 1);

    repeat ($urandom_range(0, 20)) @(negedge clk);
    c0 = cyc;
    shuffle_req = 1'b1;
    predict(c0 + 53, rc);
    @(negedge clk);
    shuffle_req = 1'b0;
    check("reshuffle ready_low", 32'(ready), 0);
    check("reshuffle cards_left", 32'(cards_left), 0);
    wait_ready("reshuffle", rc, -1, -1);
    check("reshuffle low_cycles_ge_103", 32'((cyc - c0 - 1) >= 103), 1);
`endif

    // Randomly spaced draws from the fresh deck.
    ptr = 0;
    n = $urandom_range(8, 20);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      draw_one("rand", model_deck[ptr], 51 - ptr);
      ptr++;
    end

    // Shuffle and draw together: shuffle wins.
    repeat ($urandom_range(0, 5)) @(negedge clk);
    c0 = cyc;
    draw_req = 1'b1;
    shuffle_req = 1'b1;
    predict(c0 + 53, rc);
    @(negedge clk);
    draw_req = 1'b0;
    shuffle_req = 1'b0;
    check("both valid", 32'(card_valid), 0);
    check("both ready_low", 32'(ready), 0);
    check("both cards_left", 32'(cards_left), 0);
    wait_ready("both", rc, -1, -1);
    draw_one("both first", model_deck[0], 51);

    // Reset on the same cycle as a draw.
    draw_req = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_draw");
    @(negedge clk);
    draw_req = 1'b0;
    check("rst_draw no_valid", 32'(card_valid), 0);

    // Reset mid-SHUFFLE, then identical replay of the clean boot.
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("midshuf not_ready", 32'(ready), 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midshuf");
    @(negedge clk);
    rst = 1'b1;
    predict(52, rc);
    wait_ready("replay", rc, 60, 30);
    draw_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) draw_req = 1'b0;
      check_card("replay", first_deck[k], 51 - k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/card_deck.md
# card_deck

Upstream card source for the blackjack controller. After reset or on request, it builds a 52-card deck in registers and shuffles it in place with a seeded 6-bit LFSR (Fisher-Yates with rejection sampling). It then serves one card per draw request with a single-cycle valid pulse. The controller issues draws when it deals to the player or the dealer, and uses the rank/value outputs for hand sums.

## Interface
Parameters:
- SEED, 6'b011110, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- shuffle_req  in  1  one-cycle pulse, active high; rebuilds and reshuffles the deck.
- draw_req  in  1  one-cycle pulse, active high; requests the next card.
- ready  out  1  high only in READY (deck shuffled, draws accepted).
- card_valid  out  1  one-cycle pulse; card outputs are valid when high.
- card_rank  out  4  1..13 (A, 2..10, J, Q, K); holds the last value.
- card_suit  out  2  0..3; holds the last value.
- card_value  out  4  blackjack value: A=1, 2..10 face value, J/Q/K=10; holds the last value.
- cards_left  out  6  undealt cards, 0..52.
- deck_empty  out  1  ready && cards_left==0.

## Operation
- Deck: 52 x 6-bit register array. An entry k encodes suit = k/13 and rank = (k mod 13)+1.
- LFSR: 6-bit Fibonacci generator.
  - Update: lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - It advances every cycle in every state (free-running), so player timing adds entropy.
  - It never holds 0. Candidate j = lfsr-1, range 0..62.
- States:
  - INIT: write deck[k]=k for k=0..51, one entry per cycle. Index i=51, ptr=0 on exit. Next state: SHUFFLE.
  - SHUFFLE: each cycle, if j<=i, swap deck[i] and deck[j] in that cycle and decrement i; otherwise reject (no change). When a swap occurs with i==1, the next state is READY and cards_left is set to 52.
  - READY:
    - draw_req with cards_left>0 → next cycle: card_valid=1, outputs decoded from deck[ptr], ptr++, cards_left--.
    - shuffle_req → INIT. cards_left=0 and ready=0 on the next cycle.
- Arithmetic: the j<=i compare is 6-bit unsigned. The rank/suit decode is combinational from the 6-bit entry by compare-subtract (no divider).

## Timing
- Reset values: ready=0, card_valid=0, card_rank=0, card_suit=0, card_value=0, cards_left=0, deck_empty=0. The state machine resets to INIT with lfsr=SEED.
- Draw latency: exactly 1 cycle from the draw_req sample to card_valid. Back-to-back draws on consecutive cycles are each served.
- INIT takes 52 cycles. SHUFFLE takes at least 51 cycles; the exact count depends on SEED and request timing but is deterministic for identical stimulus.
- draw_req outside READY is ignored and produces no card, no pulse, and no queueing.
- shuffle_req during INIT or SHUFFLE is ignored.
- shuffle_req and draw_req in the same cycle in READY: shuffle wins and no card is issued.
- Empty deck: draw_req while deck_empty is ignored. cards_left stays 0 and card outputs hold.
- Reset asserted mid-INIT, mid-SHUFFLE, or on the same cycle as a draw: all outputs return to reset values immediately and no card_valid is emitted.

## Configuration
- CARD_DECK_AUTO_RESHUFFLE_EN defined: the draw that takes the last card (cards_left 1→0) still produces its card_valid pulse. On the following cycle the block enters INIT automatically, with ready=0; deck_empty is never observed high.
- Not defined: the block stays in READY with deck_empty=1 until shuffle_req.

## Test plan
- Reset with SEED=6'b011110 → ready=0, cards_left=0. The first LFSR step gives 6'b111101. ready rises within 52+51..~600 cycles and cards_left=52.
- 52 back-to-back draws → 52 card_valid pulses. Each (suit, rank) pair appears exactly once, and the card_value sum is 4*(1+2+...+10+10+10+10)=340. cards_left ends at 0 and deck_empty=1 (macro off).
- With the macro off, a 53rd draw_req → no card_valid and outputs unchanged. shuffle_req → ready low for ≥103 cycles, then cards_left=52.
- Same-cycle shuffle_req+draw_req in READY → no card_valid, ready=0 next cycle. A draw_req during SHUFFLE → ignored.
- Reset asserted at cycle 60 (mid-SHUFFLE) and released → identical card sequence to a clean reset with the same stimulus timing.
- With the macro on, drawing 52 cards → the 52nd card_valid, then ready=0 next cycle, then ready=1 again with cards_left=52.
